// File: rtl/serial_sub.sv
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial WIDTH-bit subtractor (LSB first, borrow chain) with a
//            start/busy/done handshake. Define SERIAL_SUB_ADD_EN to add a
//            mode_i port selecting addition (mode_i=1) or subtraction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
`ifdef SERIAL_SUB_ADD_EN
  input  logic             mode_i,
`endif
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] D_o,
  output logic             Bout_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_SHIFT = 2'd1;
  localparam logic [1:0]    S_DONE  = 2'd2;
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic w_a;
  logic w_a_eff;
  logic w_b;
  logic w_d;
  logic w_bout;

  assign w_a = r_a_sr[0];
  assign w_b = r_b_sr[0];

  // Borrow is the carry-out cell with the minuend bit inverted.
`ifdef SERIAL_SUB_ADD_EN
  logic r_mode;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_mode <= mode_i;
    end
  end

  assign w_a_eff = r_mode ? w_a : ~w_a;
`else
  assign w_a_eff = ~w_a;
`endif

  assign w_d    = w_a ^ w_b ^ r_borrow;
  assign w_bout = (w_a_eff & w_b) | ((w_a_eff ^ w_b) & r_borrow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a_sr   <= A_i;
            r_b_sr   <= B_i;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_d_sr   <= {w_d, r_d_sr[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_d     <= {w_d, r_d_sr[WIDTH-1:1]};
            r_bout  <= w_bout;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (r_state == S_SHIFT);
  assign done_o = (r_state == S_DONE);
  assign D_o    = r_d;
  assign Bout_o = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Directed self-checking bench for serial_sub with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub;

  localparam int W = 8;

  logic         clk_i;
  logic         rst_ni;
  logic         start_i;
  logic         mode_i;
  logic [W-1:0] A_i;
  logic [W-1:0] B_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] D_o;
  logic         Bout_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] exp_q[$];

  serial_sub #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
`ifdef SERIAL_SUB_ADD_EN
    .mode_i  (mode_i),
`endif
    .A_i     (A_i),
    .B_i     (B_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .D_o     (D_o),
    .Bout_o  (Bout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: {borrow/carry, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic m);
    logic [W:0] r;
    if (m) r = {1'b0, a} + {1'b0, b};
    else   r = {(a < b), a - b};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_D"}, 32'(D_o), 32'(e[W-1:0]));
      chk({tag, "_Bout"}, 32'(Bout_o), 32'(e[W]));
    end
  endtask

  // One operation; optionally pulses start with new operands at edge 4.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input bit disturb);
    int k;
    int busy_cnt;
    @(negedge clk_i);
    A_i = a; B_i = b; mode_i = m; start_i = 1'b1;
    exp_q.push_back(model(a, b, m));
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    k        = 0;
    busy_cnt = 0;
    while (!done_o && k < 4 * W) begin
      if (busy_o) busy_cnt++;
      if (disturb && k == 3) begin
        start_i = 1'b1; A_i = ~a; B_i = b ^ 8'h5C; mode_i = ~m;
      end
      if (disturb && k == 4) start_i = 1'b0;
      @(negedge clk_i);
      k++;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, "_done_latency"}, 32'(k), 32'(W));
    pop_chk(tag);
    @(negedge clk_i);
    chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; A_i = '0; B_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_D",    32'(D_o),    32'd0);
    chk("rst_Bout", 32'(Bout_o), 32'd0);
    rst_ni = 1'b1;

    run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 1'b0);
    run_op("sub_FF_FF", 8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b0);

    // Start held high: accepted only at edges 0, 10, 20.
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (c > 0) begin
        chk("b2b_done_timing", 32'(done_o), 32'(((c - 1) % 10) == 8));
        if (done_o) pop_chk("b2b");
      end
      ra = W'($urandom); rb = W'($urandom);
      A_i = ra; B_i = rb; mode_i = 1'b0; start_i = 1'b1;
      if (c % 10 == 0) exp_q.push_back(model(ra, rb, 1'b0));
      @(posedge clk_i);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    chk("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk_i);
    chk("b2b_idle_after", 32'(busy_o), 32'd0);

    run_op("sub_mid_start", 8'h5A, 8'h33, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("no_second_op_busy", 32'(busy_o), 32'd0);
    chk("D_held", 32'(D_o), 32'h27);

    // Asynchronous reset between edges 3 and 4 of an operation.
    @(negedge clk_i);
    A_i = 8'hC3; B_i = 8'h11; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_D",    32'(D_o),    32'd0);
    chk("arst_Bout", 32'(Bout_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (i == 2) rst_ni = 1'b1;
      chk("arst_no_done", 32'(done_o), 32'd0);
    end
    run_op("sub_after_rst", 8'h80, 8'h7F, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
    run_op("add_FF_01", 8'hFF, 8'h01, 1'b1, 1'b0);
    run_op("add_12_34", 8'h12, 8'h34, 1'b1, 1'b0);
    run_op("sub_mode0", 8'h12, 8'h34, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
